// File: rtl/ps2_host_tx_if.sv
`timescale 1ns/1ps
// Host-side command bundle for ps2_host_tx.
// Carries the command byte and send strobe in, and the busy/done/ack_ok/err status out.
// master: the system issuing commands; slave: the transmitter.
interface ps2_host_tx_if;
    logic [7:0] din;     // command byte, sampled on an accepted send
    logic       send;    // request strobe, accepted only while busy=0
    logic       busy;    // transfer in progress
    logic       done;    // one-cycle pulse at end of transfer
    logic       ack_ok;  // device ACK seen, held until the next accept
    logic       err;     // NACK or timeout, held until the next accept

    modport master (
        output din,
        output send,
        input  busy,
        input  done,
        input  ack_ok,
        input  err
    );

    modport slave (
        input  din,
        input  send,
        output busy,
        output done,
        output ack_ok,
        output err
    );
endinterface

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: sends one command byte over the open-drain clock/data pair.
// Latency: busy the cycle after send; each bit lands 3 clk after a device clock falling edge.
// Backpressure: send is ignored while busy=1; the next send may be accepted the cycle after done.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   host (slave)      din/send in, busy/done/ack_ok/err out
//   ps2_clk_in        PS/2 clock line (asynchronous)
//   ps2_data_in       PS/2 data line (asynchronous)
//   ps2_clk_oe        1 pulls the clock line low, 0 releases it
//   ps2_data_oe       1 pulls the data line low, 0 releases it
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    ps2_host_tx_if.slave host,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // One counter serves both the inhibit interval and the frame timeout,
    // since the two never run at the same time.
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_TX,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t           state_q,     state_d;
    logic [2:0]       clk_sync_q,  clk_sync_d;
    logic [2:0]       data_sync_q, data_sync_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    logic [7:0]       shift_q,     shift_d;
    logic             parity_q,    parity_d;
    logic             clk_oe_q,    clk_oe_d;
    logic             data_oe_q,   data_oe_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             ack_ok_q,    ack_ok_d;
    logic             err_q,       err_d;

    logic clk_fall;
    logic line_idle;

    // Falling edge of the device clock, seen two flops deep.
    assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
    // Both lines high on two consecutive samples before the frame is closed,
    // so a single glitch high at the end of the ACK pulse is not taken as idle.
    assign line_idle = clk_sync_q[2] & clk_sync_q[1] & data_sync_q[2] & data_sync_q[1];

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
        data_sync_d = {data_sync_q[1:0], ps2_data_in};
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ack_ok_d    = ack_ok_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (host.send) begin
                    state_d   = S_INHIBIT;
                    shift_d   = host.din;
                    parity_d  = ~^host.din;
                    ack_ok_d  = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    // Request-to-send: start bit goes low while clock is still held.
                    state_d   = S_REQ;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_REQ: begin
                // Releasing the clock hands clocking to the device; timeout starts now.
                state_d   = S_TX;
                clk_oe_d  = 1'b0;
                cnt_d     = '0;
                bit_cnt_d = '0;
            end

            S_TX, S_WAIT_IDLE: begin
                if (cnt_q == TMO_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    ack_ok_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == S_TX) begin
                        if (clk_fall) begin
                            // bit_cnt_q holds the number of edges already seen.
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q < 4'd8) begin
                                data_oe_d = ~shift_q[0];
                                shift_d   = {1'b0, shift_q[7:1]};
                            end else if (bit_cnt_q == 4'd8) begin
                                data_oe_d = ~parity_q;
                            end else if (bit_cnt_q == 4'd9) begin
                                data_oe_d = 1'b0;
                            end else begin
                                // Eleventh edge: device drives ACK low.
                                data_oe_d = 1'b0;
                                state_d   = S_WAIT_IDLE;
                                if (data_sync_q[1]) begin
                                    err_d = 1'b1;
                                end else begin
                                    ack_ok_d = 1'b1;
                                end
                            end
                        end
                    end else if (line_idle) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_ok_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_ok_q    <= ack_ok_d;
            err_q       <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.ack_ok = ack_ok_q;
    assign host.err    = err_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

- PS/2 host-to-device transmitter.
- Sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) from the host to the keyboard over the shared open-drain clock/data pair, then reports whether the device acknowledged.
- Sits beside `ps2_keyboard` (device-to-host receiver) on the same two wires. While this block is busy, `ps2_keyboard` sees the host frame and must be ignored or held off by the system.

## Interface
- `INHIBIT_CYCLES`, default 10000: `clk` cycles the host holds `ps2_clk` low before the request (100 us at 100 MHz).
- `TIMEOUT_CYCLES`, default 1500000: maximum `clk` cycles from clock release to end of frame (15 ms at 100 MHz).
- `clk` in 1: system clock. One clock; all state is in this domain.
- `rst` in 1: reset, asynchronous, active-high.
- `din` in 8: command byte; sampled when `send` is accepted.
- `send` in 1: request strobe; accepted only when `busy`=0.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at end of transfer.
- `ack_ok` out 1: device ACK seen; valid while `done`=1, held until the next accept.
- `err` out 1: NACK or timeout; valid while `done`=1, held until the next accept.
- `ps2_clk_in` in 1: PS/2 clock line, asynchronous.
- `ps2_data_in` in 1: PS/2 data line, asynchronous.
- `ps2_clk_oe` out 1: 1 means pull the clock line low; 0 means release it.
- `ps2_data_oe` out 1: 1 means pull the data line low; 0 means release it.

## Operation
- **Input synchronisers.** `ps2_clk_in` and `ps2_data_in` each pass through a 3-flop synchroniser.
  - Falling edge = `clk_sync[2]` & ~`clk_sync[1]`.
  - Data sampled from `data_sync[1]`.
- **Frame.** Start(0), `din[0..7]` LSB first, odd parity (~^`din`), stop(1, line released), device ACK(0).
- **States:**
  - **IDLE**
    - `busy`=0, both `oe`=0.
    - `send`=1 latches `din` into the shift register, clears `ack_ok`/`err`, and moves to INHIBIT.
  - **INHIBIT**
    - `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
  - **REQ**
    - One cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit), then go to TX.
    - Entering TX releases the clock (`ps2_clk_oe`=0). The timeout counter clears and starts.
  - **TX**
    - Bit counter n=1..10 advances on each falling edge.
    - n=1..8: drive `din[n-1]`. `ps2_data_oe` = ~bit.
    - n=9: drive parity.
    - n=10: release data (stop bit).
    - Falling edge 11: sample data; 0 sets `ack_ok`=1, 1 sets `err`=1. Then go to WAIT_IDLE.
  - **WAIT_IDLE**
    - Wait until synced clock and data are both 1, then go to DONE.
  - **DONE**
    - One cycle: `done`=1, then return to IDLE.
- **Timeout.** In TX or WAIT_IDLE, the counter reaching `TIMEOUT_CYCLES` means:
  - release both lines;
  - `err`=1, `ack_ok`=0;
  - go to DONE.
- **`send` while busy.** Ignored, with no effect on the frame in flight.
- **Reset.** Asserting `rst` at any time, including mid-frame, immediately gives:
  - IDLE state;
  - `ps2_clk_oe`=0, `ps2_data_oe`=0;
  - `busy`=0, `done`=0, `ack_ok`=0, `err`=0;
  - counters cleared.

## Timing
- All outputs are registered. Reset values are 0.
- `busy` rises the cycle after `send` is accepted, and falls in the cycle after `done`.
- `ps2_clk_oe` is high for `INHIBIT_CYCLES`+1 cycles in total (INHIBIT plus REQ).
- `ps2_data_oe` rises one cycle before `ps2_clk_oe` falls.
- Bit change latency: the `ps2_data_oe` update lands 3 `clk` cycles after the physical falling edge (2 synchroniser flops plus 1 register). This is far inside the device's half-period of about 30 us.
- `done`-to-next-accept: `send` can be accepted in the cycle after `done`.
- Minimum `clk` frequency is 2 MHz, so that PS/2 edges (10-16.7 kHz) are resolved.

## Test plan
All scenarios use a host model that drives device clocking at 15 kHz, with `INHIBIT_CYCLES`=20 and `TIMEOUT_CYCLES`=200000.

1. **ED with ACK.** `send` with `din`=8'hED, device ACKs.
   - Clock held low exactly 21 cycles.
   - Device captures bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
   - `done` pulses once, with `ack_ok`=1, `err`=0.
2. **Parity corners.** `din`=8'h00 gives parity 1; `din`=8'hFF gives parity 1; `din`=8'h01 gives parity 0. The device model checks each, and all ACK.
3. **NACK.** Device leaves data high on edge 11: `done` with `err`=1, `ack_ok`=0.
4. **No device clocks.** After REQ, `done` with `err`=1 at 200000 cycles past clock release, and both `oe`=0.
5. **`send` while busy.** A second `send` (`din`=8'h55) during TX of 8'hF4: the device receives only F4, and only one `done` occurs.
6. **Reset mid-frame.** `rst` pulsed during bit 4: `ps2_clk_oe`=`ps2_data_oe`=0 and `busy`=0 in the same cycle. A subsequent `send` of 8'hFF completes with `ack_ok`=1.
